// File: rtl/ebnb.sv
// Elastic buffer on valid/ready streams: DEPTH-entry circular store with registered
// ready/valid, fill level, almost-full flag and synchronous flush.
module ebnb #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           t_0_data,
    input  logic                       t_0_valid,
    output logic                       t_0_ready,
    output logic [WIDTH-1:0]           i_0_data,
    output logic                       i_0_valid,
    input  logic                       i_0_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_CNT  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_CNT = LVL_W'(AFULL_LEVEL);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign t_0_ready   = (count != FULL_CNT) & ~flush;
    assign i_0_valid   = (count != '0) & ~flush;
    assign i_0_data    = mem[rd_ptr];
    assign level       = count;
    assign almost_full = (count >= AFULL_CNT);

    assign push = t_0_valid & t_0_ready;
    assign pop  = i_0_valid & i_0_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Storage is left as-is; only the bookkeeping is discarded.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= t_0_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ebnb.sv
// Randomized and directed bench for ebnb against a queue-based reference model.
module tb_ebnb;

    logic       clk;
    logic       reset_n;

    logic [7:0] a_t_data;
    logic       a_t_valid;
    logic       a_t_ready;
    logic [7:0] a_i_data;
    logic       a_i_valid;
    logic       a_i_ready;
    logic       a_flush;
    logic [2:0] a_level;
    logic       a_afull;

    logic [7:0] b_t_data;
    logic       b_t_valid;
    logic       b_t_ready;
    logic [7:0] b_i_data;
    logic       b_i_valid;
    logic       b_i_ready;
    logic       b_flush;
    logic [1:0] b_level;
    logic       b_afull;

    int n_checks;
    int n_errors;

    logic [7:0] q4[$];
    logic [7:0] q3[$];
    bit         last_push;
    bit         last_pop;
    bit         st_pend [2];
    logic [7:0] st_data [2];
    bit         up_pend [2];
    logic [7:0] up_data [2];

    ebnb #(.WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) u_dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .t_0_data   (a_t_data),
        .t_0_valid  (a_t_valid),
        .t_0_ready  (a_t_ready),
        .i_0_data   (a_i_data),
        .i_0_valid  (a_i_valid),
        .i_0_ready  (a_i_ready),
        .flush      (a_flush),
        .level      (a_level),
        .almost_full(a_afull)
    );

    ebnb #(.WIDTH(8), .DEPTH(3), .AFULL_LEVEL(2)) u_dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .t_0_data   (b_t_data),
        .t_0_valid  (b_t_valid),
        .t_0_ready  (b_t_ready),
        .i_0_data   (b_i_data),
        .i_0_valid  (b_i_valid),
        .i_0_ready  (b_i_ready),
        .flush      (b_flush),
        .level      (b_level),
        .almost_full(b_afull)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the selected instance (0: DEPTH=4, 1: DEPTH=3), entered at negedge.
    task automatic step(input int sel, input bit v, input logic [7:0] d, input bit r, input bit f);
        int         depth;
        int         afl;
        int         size;
        logic [7:0] head;
        bit         exp_rdy;
        bit         exp_vld;
        logic [31:0] o_rdy, o_vld, o_data, o_lvl, o_af;
        if (sel == 0) begin
            a_t_valid = v; a_t_data = d; a_i_ready = r; a_flush = f;
            depth = 4; afl = 3; size = q4.size();
            head = (size > 0) ? q4[0] : 8'h00;
        end else begin
            b_t_valid = v; b_t_data = d; b_i_ready = r; b_flush = f;
            depth = 3; afl = 2; size = q3.size();
            head = (size > 0) ? q3[0] : 8'h00;
        end
        #1;
        if (sel == 0) begin
            o_rdy = 32'(a_t_ready); o_vld = 32'(a_i_valid); o_data = 32'(a_i_data);
            o_lvl = 32'(a_level);   o_af  = 32'(a_afull);
        end else begin
            o_rdy = 32'(b_t_ready); o_vld = 32'(b_i_valid); o_data = 32'(b_i_data);
            o_lvl = 32'(b_level);   o_af  = 32'(b_afull);
        end
        exp_rdy = (size < depth) && !f;
        exp_vld = (size > 0) && !f;
        if (up_pend[sel]) check("upstream_hold", {23'd0, v, d}, {23'd0, 1'b1, up_data[sel]});
        if (st_pend[sel]) check("data_stable", o_data, 32'(st_data[sel]));
        check("t_0_ready", o_rdy, 32'(exp_rdy));
        check("i_0_valid", o_vld, 32'(exp_vld));
        check("level", o_lvl, 32'(size));
        check("almost_full", o_af, 32'(size >= afl));
        if (exp_vld) check("i_0_data", o_data, 32'(head));
        last_push = v && exp_rdy;
        last_pop  = exp_vld && r;
        st_pend[sel] = exp_vld && !r;
        st_data[sel] = o_data[7:0];
        up_pend[sel] = v && !exp_rdy;
        up_data[sel] = d;
        @(posedge clk);
        if (sel == 0) begin
            if (f) q4.delete();
            else begin
                if (last_pop) void'(q4.pop_front());
                if (last_push) q4.push_back(d);
            end
        end else begin
            if (f) q3.delete();
            else begin
                if (last_pop) void'(q3.pop_front());
                if (last_push) q3.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_a_t_ready", 32'(a_t_ready), 32'd1);
        check("rst_a_i_valid", 32'(a_i_valid), 32'd0);
        check("rst_a_i_data", 32'(a_i_data), 32'd0);
        check("rst_a_level", 32'(a_level), 32'd0);
        check("rst_a_afull", 32'(a_afull), 32'd0);
        check("rst_b_t_ready", 32'(b_t_ready), 32'd1);
        check("rst_b_i_valid", 32'(b_i_valid), 32'd0);
        check("rst_b_level", 32'(b_level), 32'd0);
    endtask

    initial begin
        int pops;
        int accepted;
        int cyc;
        bit         v;
        logic [7:0] d;
        bit         r;
        n_checks = 0;
        n_errors = 0;
        st_pend = '{0, 0};
        up_pend = '{0, 0};
        reset_n = 1'b0;
        a_t_valid = 0; a_t_data = 0; a_i_ready = 0; a_flush = 0;
        b_t_valid = 0; b_t_data = 0; b_i_ready = 0; b_flush = 0;
        @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to full with downstream stalled, then hold 0x55 against a full buffer.
        step(0, 1, 8'h11, 0, 0);
        step(0, 1, 8'h22, 0, 0);
        step(0, 1, 8'h33, 0, 0);
        step(0, 1, 8'h44, 0, 0);
        step(0, 1, 8'h55, 0, 0);
        step(0, 1, 8'h55, 0, 0);
        check("full_level", 32'(a_level), 32'd4);

        // Drain from full; 0x55 gets in only after the first pop.
        step(0, 1, 8'h55, 1, 0);
        check("drain_c1_pop", 32'(last_pop), 32'd1);
        step(0, 1, 8'h55, 1, 0);
        check("drain_c2_push", 32'(last_push), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
        check("drain_empty", 32'(a_i_valid), 32'd0);

        // Flush with a live upstream beat and ready downstream.
        step(0, 1, 8'hA0, 0, 0);
        step(0, 1, 8'hA1, 0, 0);
        step(0, 1, 8'hB0, 1, 1);
        check("flush_no_push", 32'(last_push), 32'd0);
        check("flush_no_pop", 32'(last_pop), 32'd0);
        step(0, 1, 8'hB0, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check("flush_next_pop", 32'(last_pop), 32'd1);

        // Asynchronous reset mid-stream at level 3.
        step(0, 1, 8'hC0, 0, 0);
        step(0, 1, 8'hC1, 0, 0);
        step(0, 1, 8'hC2, 0, 0);
        check("pre_reset_level", 32'(a_level), 32'd3);
        a_t_valid = 0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        q4.delete();
        st_pend = '{0, 0};
        up_pend = '{0, 0};
        @(negedge clk);
        reset_n = 1'b1;

        // Full-rate streaming through the DEPTH=3 instance.
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(i), 1, 0);
            if (last_pop) pops++;
            if (i > 0) check("stream_level", 32'(b_level), 32'd1);
        end
        step(1, 0, 8'h00, 1, 0);
        if (last_pop) pops++;
        check("stream_beats", 32'(pops), 32'd20);

        // Random valid/ready on the DEPTH=4 instance.
        accepted = 0;
        cyc = 0;
        while ((accepted < 1000 || q4.size() > 0) && cyc < 8000) begin
            if (up_pend[0]) begin
                v = 1'b1;
                d = up_data[0];
            end else begin
                v = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                d = 8'($urandom);
            end
            r = 1'($urandom_range(0, 1));
            step(0, v, d, r, 0);
            if (last_push) accepted++;
            cyc++;
        end
        check("random_accepted", 32'(accepted), 32'd1000);
        check("random_drained", 32'(q4.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ebnb.md
Name: ebnb

Overview:
- Parametrised N-entry elastic buffer. Successor to the two-entry skid buffer on valid/ready streams.
- Adds configurable DEPTH, a fill-level output, an almost-full flag and a synchronous flush.
- Both directions are registered: no combinational path from t_0_valid/t_0_data to i_0_*, and none from i_0_ready to t_0_ready.
- Sits between pipeline stages or across module boundaries in the FPGA datapaths to absorb bursty backpressure.

Parameters:
- WIDTH, 8, data width in bits of t_0_data and i_0_data.
- DEPTH, 4, number of storage entries; legal range 2..256, not required to be a power of two.
- AFULL_LEVEL, 3, level at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- t_0_data  input  WIDTH  upstream beat data.
- t_0_valid  input  1  upstream beat valid.
- t_0_ready  output  1  buffer can accept a beat.
- i_0_data  output  WIDTH  downstream beat data (head entry).
- i_0_valid  output  1  head entry valid.
- i_0_ready  input  1  downstream accepts the beat.
- flush  input  1  synchronous discard of all contents.
- level  output  $clog2(DEPTH+1)  current entry count, 0..DEPTH.
- almost_full  output  1  level >= AFULL_LEVEL.

Behaviour:
- State: mem[DEPTH] of WIDTH bits, wr_ptr, rd_ptr (each 0..DEPTH-1), count (0..DEPTH).
- Reset (reset_n low, asynchronous, no clock required):
  - All state goes to 0, including mem.
  - Outputs: t_0_ready=1, i_0_valid=0, i_0_data=0, level=0, almost_full=0 (AFULL_LEVEL>=1).
- Handshake terms: push = t_0_valid & t_0_ready; pop = i_0_valid & i_0_ready.
- t_0_ready = (count != DEPTH) & ~flush. Derived from registered count and flush only.
- i_0_valid = (count != 0) & ~flush.
- i_0_data = mem[rd_ptr]. Only the flush input may gate i_0_valid/t_0_ready combinationally.
- On push: mem[wr_ptr] <= t_0_data; wr_ptr advances, wrapping DEPTH-1 -> 0 explicitly (not by bit truncation).
- On pop: rd_ptr advances with the same wrap rule.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both or neither occur.
- Latency: a beat accepted in cycle N is presentable on i_0 in cycle N+1. Full throughput of one beat per cycle in steady state when neither side stalls.
- Order: strict FIFO.
- Stability: while i_0_valid=1 and i_0_ready=0, i_0_data holds constant. A push never writes rd_ptr while count>0, because wr_ptr==rd_ptr only when count is 0 or DEPTH.
- Full (count==DEPTH): t_0_ready=0 even if i_0_ready=1 that cycle. Ready returns the cycle after the pop.
- Empty (count==0): i_0_valid=0. A beat pushed now is not bypassed; it appears next cycle.
- Simultaneous push and pop at count 1..DEPTH-1: count unchanged, both pointers advance.
- Flush=1:
  - t_0_ready=0 and i_0_valid=0 in that cycle, so no handshake completes.
  - On the clock edge, wr_ptr, rd_ptr and count clear to 0.
  - mem contents are not cleared (don't care).
  - After the edge: level=0 and i_0_valid=0 while flush stays low.
  - Multi-cycle flush holds the buffer empty.
- i_0_data when i_0_valid=0: mem[rd_ptr], don't care for protocol; equals 0 after reset.
- level = count; almost_full = (count >= AFULL_LEVEL). Both are combinational from registered count and not gated by flush.
- Upstream must hold t_0_data/t_0_valid while t_0_valid & ~t_0_ready. Buffer behaviour is undefined otherwise; a bench assertion checks this.

Test Plan:
- Reset: assert reset_n=0 mid-stream with level=3, no clock edge -> immediately t_0_ready=1, i_0_valid=0, i_0_data=0, level=0, almost_full=0.
- Fill, DEPTH=4, AFULL_LEVEL=3, i_0_ready=0: push 0x11,0x22,0x33,0x44 -> level 1,2,3,4; almost_full rises when level=3; t_0_ready=0 at level 4; a held 0x55 is not accepted; i_0_data stays 0x11 throughout.
- Drain from full: raise i_0_ready with 0x55 still held -> cycle 1 pops 0x11 and t_0_ready stays 0; cycle 2 accepts 0x55 and pops 0x22. Output order is 0x11..0x55 with no loss or duplication.
- Streaming, DEPTH=3 (non-power-of-two): 20 beats 0x00..0x13 with valid/ready both high every cycle -> one beat per cycle at 1-cycle latency; level constant at 1; pointers wrap 2->0 correctly.
- Flush: hold level=2 (0xA0,0xA1), pulse flush for 1 cycle with t_0_valid=1 data 0xB0 and i_0_ready=1 -> no handshake in the flush cycle; next cycle level=0 and i_0_valid=0; then 0xB0 is accepted and is the next output.
- Random stall: 1000 beats with random t_0_valid and i_0_ready at 50% each -> scoreboard order matches, level never exceeds DEPTH, and the i_0_data-stable-while-stalled assertion passes.
